// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared command encoding, player states and board timing constants
package robot_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int STEP_MS = 2000;
  // Dwell per command expressed in clock cycles (2 s at 50 MHz).
  localparam int DEFAULT_STEP_CYCLES = (CLK_HZ / 1000) * STEP_MS;

  // Shared with the programming stage and the display/torque decoder.
  typedef enum logic [1:0] {
    CMD_FWD   = 2'b00,
    CMD_RIGHT = 2'b01,
    CMD_LEFT  = 2'b10,
    CMD_BACK  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_RUN,
    ST_DONE
  } player_state_t;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter that flags the cycle its count reaches zero
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_i           force the count to zero (used on abort)
//   load_i          load load_val_i (takes priority over enable)
//   load_val_i      value to load
//   en_i            decrement while count is non-zero
//   expire_o        high while enabled and the count is zero
module step_timer #(
  parameter int TMR_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/command_player.sv
// rtl/command_player.sv - plays stored direction commands with a fixed dwell per command
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, abort  single-cycle pulses; abort wins when both are high
//   cmd_count     number of stored commands (0..2**ADDR_W), latched on accepted start
//   rd_en/rd_addr read request to the command buffer (synchronous, 1-cycle latency)
//   rd_data       command word returned by the buffer
//   cmd_valid     cmd_code/step_index are being executed this cycle
//   cmd_code      current (or, in DONE, last) command
//   step_index    index of current (or last) command
//   busy          high while fetching or executing
//   done          playback finished; held until abort or a new start
module command_player
  import robot_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES,
  parameter int TMR_W       = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              cmd_valid,
  output logic [1:0]        cmd_code,
  output logic [ADDR_W-1:0] step_index,
  output logic              busy,
  output logic              done
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);

  player_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cmd_valid_q, cmd_valid_d;
  cmd_t              cmd_code_q, cmd_code_d;
  logic [ADDR_W-1:0] step_index_q, step_index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_clr, tmr_load, tmr_en, tmr_expire;
  // One bit wider than idx so a full 2**ADDR_W buffer terminates instead of wrapping.
  logic [ADDR_W:0]   next_idx;

  assign next_idx = {1'b0, idx_q} + (ADDR_W+1)'(1);

  step_timer #(
    .TMR_W(TMR_W)
  ) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .load_i    (tmr_load),
    .load_val_i(TMR_LOAD),
    .en_i      (tmr_en),
    .expire_o  (tmr_expire)
  );

  // Outputs are registered, so each *_d is the value to show in the state being entered.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    step_index_d = step_index_q;
    busy_d       = busy_q;
    done_d       = done_q;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    if (abort) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      count_d      = '0;
      rd_addr_d    = '0;
      cmd_code_d   = CMD_FWD;
      step_index_d = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      tmr_clr      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (cmd_count != '0) begin
              state_d   = ST_FETCH;
              count_d   = cmd_count;
              idx_d     = '0;
              rd_en_d   = 1'b1;
              rd_addr_d = '0;
              busy_d    = 1'b1;
              done_d    = 1'b0;
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          // Buffer data is valid now, one cycle after the read strobe.
          state_d      = ST_RUN;
          cmd_code_d   = cmd_t'(rd_data);
          step_index_d = idx_q;
          cmd_valid_d  = 1'b1;
          tmr_load     = 1'b1;
        end
        ST_RUN: begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            if (next_idx < count_q) begin
              state_d   = ST_FETCH;
              idx_d     = next_idx[ADDR_W-1:0];
              rd_en_d   = 1'b1;
              rd_addr_d = next_idx[ADDR_W-1:0];
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cmd_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= CMD_FWD;
      step_index_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      step_index_q <= step_index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign step_index = step_index_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_command_player.sv
// tb/tb_command_player.sv - scoreboard bench for command_player with a 4-cycle dwell
module tb_command_player;

  localparam int ADDR_W = 8;
  localparam int STEP   = 4;
  localparam int PER    = STEP + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   cmd_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              cmd_valid;
  logic [1:0]        cmd_code;
  logic [ADDR_W-1:0] step_index;
  logic              busy;
  logic              done;

  command_player #(
    .ADDR_W     (ADDR_W),
    .STEP_CYCLES(STEP),
    .TMR_W      (27)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cmd_count (cmd_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .step_index(step_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Command buffer model: registered read, data one cycle after rd_en.
  logic [1:0] mem [256];
  always @(posedge clk) if (rd_en === 1'b1) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // kind 0: rd_en observed (idx = rd_addr); kind 1: cmd_valid observed.
  typedef struct {
    int kind;
    int cyc;
    int idx;
    int code;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int idx, input int code);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.code = code;
    exp_q.push_back(e);
  endtask

  // One command: fetch at s, then nvalid execute cycles starting at s+2.
  task automatic push_cmd(input int s, input int idx, input int nvalid);
    push_ev(0, s, idx, 0);
    for (int v = 0; v < nvalid; v++) push_ev(1, s + 2 + v, idx, int'(mem[idx]));
  endtask

  task automatic push_play(input int s, input int n);
    for (int i = 0; i < n; i++) push_cmd(s + PER * i, i, STEP);
  endtask

  task automatic mon(input int kind, input int idx, input int code);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d idx=%0d code=%0d expected no event",
               kind, cyc, idx, code);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != idx || e.code != code) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d idx=%0d code=%0d expected kind=%0d cyc=%0d idx=%0d code=%0d",
                 kind, cyc, idx, code, e.kind, e.cyc, e.idx, e.code);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_en === 1'b1) mon(0, int'(rd_addr), 0);
    if (cmd_valid === 1'b1) mon(1, int'(step_index), int'(cmd_code));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_cmd_valid"}, int'(cmd_valid), 0);
    check({tag, "_cmd_code"}, int'(cmd_code), 0);
    check({tag, "_step_index"}, int'(step_index), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic drain(input string tag);
    check({tag, "_missing_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_count = '0;
    for (int i = 0; i < 256; i++) mem[i] = 2'(i);
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Four commands 00,01,10,11; cmd_count change after start must be ignored.
    cmd_count = 9'd4;
    pulse_start(s);
    cmd_count = 9'd1;
    push_play(s, 4);
    wait_cyc(s + 4 * PER);
    check("play4_done", int'(done), 1);
    check("play4_busy", int'(busy), 0);
    check("play4_last_code", int'(cmd_code), 3);
    check("play4_last_index", int'(step_index), 3);
    repeat (10) tick();
    check("play4_done_held", int'(done), 1);
    check("play4_code_held", int'(cmd_code), 3);
    drain("play4");

    // Restart from DONE, with extra start pulses in WAIT_RD and RUN.
    cmd_count = 9'd4;
    pulse_start(s);
    push_play(s, 4);
    check("rearm_done_cleared", int'(done), 0);
    check("rearm_busy", int'(busy), 1);
    wait_cyc(s + 1);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(s + 3);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(s + 4 * PER);
    check("rearm_done", int'(done), 1);
    check("rearm_last_index", int'(step_index), 3);
    drain("rearm");

    // Abort during the second command's RUN, then a clean restart.
    pulse_start(s);
    push_cmd(s, 0, STEP);
    push_cmd(s + PER, 1, 1);
    wait_cyc(s + 8);
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort");
    repeat (3) tick();
    drain("abort");
    pulse_start(s);
    push_play(s, 4);
    wait_cyc(s + 4 * PER);
    check("restart_done", int'(done), 1);
    check("restart_last_index", int'(step_index), 3);
    drain("restart");

    // Empty buffer: straight to DONE, no reads, no execution.
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort_from_done");
    cmd_count = 9'd0;
    pulse_start(s);
    check("empty_done", int'(done), 1);
    check("empty_busy", int'(busy), 0);
    repeat (6) tick();
    check("empty_done_held", int'(done), 1);
    drain("empty");

    // start and abort together in IDLE: abort wins.
    abort = 1'b1; tick(); abort = 1'b0;
    cmd_count = 9'd4;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_idle("start_abort");
    repeat (4) tick();
    check("start_abort_busy", int'(busy), 0);
    drain("start_abort");

    // Reset for one cycle in the middle of RUN.
    pulse_start(s);
    push_cmd(s, 0, 1);
    wait_cyc(s + 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle("rst_mid_run");
    repeat (3) tick();
    drain("rst_mid_run");

    // Full buffer: 256 commands, index must not wrap.
    cmd_count = 9'h100;
    pulse_start(s);
    push_play(s, 256);
    wait_cyc(s + 256 * PER);
    check("full_done", int'(done), 1);
    check("full_busy", int'(busy), 0);
    check("full_last_index", int'(step_index), 255);
    check("full_last_code", int'(cmd_code), 3);
    repeat (8) tick();
    drain("full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
